// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding for the SPI slave control FSM
package spi_pkg;
    // Low five bits are the output flags {busy, addr_we, dm_we, sr_we, miso_en}; top two disambiguate
    typedef enum logic [6:0] {
        IDLE         = 7'b00_00000,
        GET_ADDR     = 7'b00_10000,
        LATCH_ADDR   = 7'b00_11000,
        READ_WAIT    = 7'b01_10000,
        READ_LOAD    = 7'b00_10010,
        READ_SHIFT   = 7'b00_10001,
        WRITE_SHIFT  = 7'b10_10000,
        WRITE_COMMIT = 7'b00_10100,
        DONE         = 7'b11_10000
    } state_t;
endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: saturating bit counter with terminal-count flag on the FRAME_BITS-th pulse
module spi_bit_counter #(
    parameter int FRAME_BITS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);
    localparam int CW = $clog2(FRAME_BITS + 1);
    logic [CW-1:0] count;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (clr) count <= '0;
        else if (inc && count != CW'(FRAME_BITS)) count <= count + 1'b1;
    assign tc = inc && count == CW'(FRAME_BITS - 1);
endmodule

// File: rtl/spi_fsm.sv
// spi_fsm: SPI slave transaction controller (address byte, then read or write data byte)
module spi_fsm
    import spi_pkg::*;
#(
    parameter int FRAME_BITS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_posedge,
    input  logic sclk_negedge,
    input  logic cs_n,
    input  logic rw_bit,
    output logic addr_we,
    output logic dm_we,
    output logic sr_we,
    output logic miso_en,
    output logic busy
);
    state_t state, state_next;
    logic inc, clr, tc;
    assign inc = (state == GET_ADDR || state == WRITE_SHIFT) ? sclk_posedge
               : (state == READ_SHIFT) && sclk_negedge;
    assign clr = state_next != state;
    spi_bit_counter #(.FRAME_BITS(FRAME_BITS)) u_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc), .tc(tc)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    always_comb begin
        state_next = state;
        if (state != IDLE && cs_n) state_next = IDLE;
        else
            case (state)
                IDLE:         state_next = cs_n ? IDLE : GET_ADDR;
                GET_ADDR:     state_next = tc ? LATCH_ADDR : GET_ADDR;
                LATCH_ADDR:   state_next = rw_bit ? READ_WAIT : WRITE_SHIFT;
                READ_WAIT:    state_next = READ_LOAD;
                READ_LOAD:    state_next = READ_SHIFT;
                READ_SHIFT:   state_next = tc ? DONE : READ_SHIFT;
                WRITE_SHIFT:  state_next = tc ? WRITE_COMMIT : WRITE_SHIFT;
                WRITE_COMMIT: state_next = DONE;
                default:      state_next = state;
            endcase
    end
    // Outputs are flop bits of the state encoding, so they cannot glitch
    always_comb {busy, addr_we, dm_we, sr_we, miso_en} = state[4:0];
endmodule

// File: tb/tb_spi_fsm.sv
// tb_spi_fsm: directed scoreboard bench for spi_fsm
module tb_spi_fsm;
    logic clk = 0, rst_n = 0, sclk_posedge = 0, sclk_negedge = 0, cs_n = 1, rw_bit = 0;
    logic addr_we, dm_we, sr_we, miso_en, busy;
    logic [4:0] outs;
    int compared = 0, mismatched = 0;
    logic [4:0] exp_q[$];
    string tag_q[$];
    localparam logic [4:0] O_IDLE = 5'b00000, O_BUSY = 5'b10000, O_ADDR = 5'b11000,
                           O_DM = 5'b10100, O_SR = 5'b10010, O_MISO = 5'b10001;
    assign outs = {busy, addr_we, dm_we, sr_we, miso_en};
    always #5 clk = ~clk;
    spi_fsm #(.FRAME_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .sclk_posedge(sclk_posedge), .sclk_negedge(sclk_negedge),
        .cs_n(cs_n), .rw_bit(rw_bit), .addr_we(addr_we), .dm_we(dm_we), .sr_we(sr_we),
        .miso_en(miso_en), .busy(busy)
    );
    task automatic check();
        logic [4:0] e = exp_q.pop_front();
        string t = tag_q.pop_front();
        compared++;
        assert (outs === e) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", t, outs, e);
        end
    endtask
    task automatic expect_now(input logic [4:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        check();
    endtask
    task automatic step(input logic pp, input logic pn, input logic cs, input logic rw,
                        input logic [4:0] e, input string tag);
        sclk_posedge = pp;
        sclk_negedge = pn;
        cs_n = cs;
        rw_bit = rw;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check();
    endtask
    // Address byte with cs_n low; rw presented on the 8th pulse and through the latch cycle
    task automatic addr_phase(input logic rw, input logic pn_noise);
        step(0, 0, 0, 0, O_BUSY, "start");
        for (int i = 1; i <= 8; i++) begin
            step(1, pn_noise, 0, i == 8 ? rw : 1'b0, i == 8 ? O_ADDR : O_BUSY, "addr_bit");
            if (i < 8) step(0, 0, 0, 0, O_BUSY, "addr_gap");
        end
        step(0, 0, 0, rw, O_BUSY, "latch_exit");
    endtask
    initial begin
        #3 expect_now(O_IDLE, "reset_state");
        repeat (2) @(posedge clk);
        #1 expect_now(O_IDLE, "reset_hold");
        #3 rst_n = 1;
        step(0, 0, 1, 0, O_IDLE, "idle_cs_high");
        // Write: noise negedges in the data phase must not count
        addr_phase(0, 0);
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 0, 0, i == 8 ? O_DM : O_BUSY, "w_data");
            if (i < 8) step(0, 1, 0, 0, O_BUSY, "w_gap");
        end
        step(0, 0, 0, 0, O_BUSY, "w_done");
        step(1, 1, 0, 0, O_BUSY, "done_noise");
        step(0, 0, 1, 0, O_IDLE, "w_end");
        // Read: coincident negedges during the address byte are ignored
        addr_phase(1, 1);
        step(1, 1, 0, 1, O_SR, "r_load");
        step(1, 1, 0, 1, O_MISO, "r_shift");
        for (int i = 1; i <= 8; i++) begin
            step(1, 1, 0, 1, i == 8 ? O_BUSY : O_MISO, "r_data");
            if (i < 8) step(1, 0, 0, 1, O_MISO, "r_gap");
        end
        step(0, 1, 0, 1, O_BUSY, "r_done_hold");
        step(0, 0, 1, 0, O_IDLE, "r_end");
        // Abort after 12th posedge of a write
        addr_phase(0, 0);
        for (int i = 1; i <= 4; i++) step(1, 0, 0, 0, O_BUSY, "ab_data");
        step(0, 0, 1, 0, O_IDLE, "abort");
        for (int i = 0; i < 6; i++) step(1, 0, 1, 0, O_IDLE, "ab_after");
        // cs_n rises together with the 8th address posedge
        step(0, 0, 0, 0, O_BUSY, "co_start");
        for (int i = 1; i <= 7; i++) step(1, 0, 0, 0, O_BUSY, "co_addr");
        step(1, 0, 1, 0, O_IDLE, "coincidence");
        step(0, 0, 1, 0, O_IDLE, "co_after");
        // Async reset in READ_SHIFT, then a fresh transaction with cs_n held low
        addr_phase(1, 0);
        step(0, 0, 0, 1, O_SR, "rs_load");
        step(0, 0, 0, 1, O_MISO, "rs_shift");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, O_MISO, "rs_data");
        #1 rst_n = 0;
        #1 expect_now(O_IDLE, "rst_async");
        @(posedge clk);
        #1 expect_now(O_IDLE, "rst_held");
        #2 rst_n = 1;
        addr_phase(0, 0);
        for (int i = 1; i <= 8; i++) step(1, 0, 0, 0, i == 8 ? O_DM : O_BUSY, "rs_w_data");
        step(0, 0, 0, 0, O_BUSY, "rs_w_done");
        step(0, 0, 1, 0, O_IDLE, "rs_end");
        // Noise in IDLE
        for (int i = 0; i < 20; i++)
            step(1'($urandom), 1'($urandom), 1, 1'($urandom), O_IDLE, "idle_noise");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/spi_fsm.md
SPI_FSM -- requirements
Module: spi_fsm

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 8: bits per SPI byte, covering both the address/RW byte and the data byte.
REQ-002 SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset; asynchronous, active-low.
REQ-004 SHALL have port sclk_posedge, input, 1: one-clk pulse from the conditioned SPI clock's rising edge (shift/sample event).
REQ-005 SHALL have port sclk_negedge, input, 1: one-clk pulse from the conditioned SPI clock's falling edge (MISO advance event).
REQ-006 SHALL have port cs_n, input, 1: conditioned chip select, active-low.
REQ-007 SHALL have port rw_bit, input, 1: shift-register parallel output bit 0; 1 = read, 0 = write.
REQ-008 SHALL have port addr_we, output, 1: address latch write enable.
REQ-009 SHALL have port dm_we, output, 1: data memory write enable.
REQ-010 SHALL have port sr_we, output, 1: shift-register parallel load.
REQ-011 SHALL have port miso_en, output, 1: MISO tri-state buffer enable.
REQ-012 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement the states IDLE, GET_ADDR, LATCH_ADDR, READ_WAIT, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_COMMIT and DONE.
REQ-014 IDLE: on cs_n=0, SHALL go to GET_ADDR and clear the bit counter.
REQ-015 GET_ADDR: SHALL increment the counter on each sclk_posedge; on the FRAME_BITS-th pulse SHALL go to LATCH_ADDR and clear the counter.
REQ-016 LATCH_ADDR: SHALL assert addr_we for exactly one clk, sample rw_bit, and go to READ_WAIT if rw_bit=1, else to WRITE_SHIFT.
REQ-017 READ_WAIT: SHALL last one clk with all outputs low except busy, to allow memory read latency, then go to READ_LOAD.
REQ-018 READ_LOAD: SHALL assert sr_we for exactly one clk, then go to READ_SHIFT.
REQ-019 READ_SHIFT: SHALL hold miso_en=1 and count sclk_negedge pulses; on the FRAME_BITS-th pulse SHALL go to DONE.
REQ-020 WRITE_SHIFT: SHALL count sclk_posedge pulses; on the FRAME_BITS-th pulse SHALL go to WRITE_COMMIT.
REQ-021 WRITE_COMMIT: SHALL assert dm_we for exactly one clk, then go to DONE.
REQ-022 DONE: SHALL drive all outputs low except busy, and go to IDLE when cs_n=1.
REQ-023 In any state except IDLE, cs_n=1 SHALL force IDLE on the next clk edge; this abort SHALL take priority over a coincident sclk pulse and SHALL suppress a pending dm_we.
REQ-024 Outputs SHALL be registered or decoded purely from state, and SHALL be glitch-free.
REQ-025 The counter SHALL be $clog2(FRAME_BITS+1) bits wide and SHALL never wrap; it clears on every state entry.
REQ-026 sclk pulses arriving in IDLE, LATCH_ADDR, READ_WAIT, READ_LOAD, WRITE_COMMIT or DONE SHALL be ignored.
REQ-027 Simultaneous sclk_posedge and sclk_negedge SHALL have each pulse counted only by the state that uses that pulse type.

Reset
REQ-028 While rst_n=0, the block SHALL be in state IDLE with counter=0 and addr_we=dm_we=sr_we=miso_en=busy=0, immediately and independently of clk.
REQ-029 Reset asserted mid-transaction SHALL abort the transaction with no dm_we pulse; after release, the block SHALL wait for a fresh cs_n falling level.

Structure
REQ-030 The state enumeration and its encoding SHALL live in the shared package spi_pkg.
REQ-031 The bit counter (clear, increment-on-pulse, terminal-count flag) SHALL be the single sub-module spi_bit_counter.

Verification
REQ-032 Write: cs_n=0, 8 posedges with rw_bit=0 at the 8th, then 8 more posedges -> addr_we one clk after the 8th pulse, dm_we one clk after the 16th pulse, then DONE.
REQ-033 Read: cs_n=0, 8 posedges with rw_bit=1 -> addr_we, then one idle clk, then sr_we for one clk; miso_en high until the 8th negedge, then DONE.
REQ-034 Abort: cs_n rises after the 12th posedge of a write -> IDLE next clk, dm_we never asserted, busy=0.
REQ-035 Coincidence: cs_n=1 in the same clk as the 8th address posedge -> IDLE, addr_we stays 0.
REQ-036 Reset: rst_n=0 in READ_SHIFT between clk edges -> miso_en=0 and busy=0 immediately; with cs_n held low after release -> new GET_ADDR.
REQ-037 Noise immunity: 20 sclk pulses while in IDLE with cs_n=1 -> no output ever asserts.
